// File: rtl/flit_uart_tx_serializer.sv
// Frames one flit as comma + MSB-first data bytes into a byte UART, gated by link credits.
// Latency: comma start one edge after accept when the UART is idle; flit_ready low while framing or out of credits.
module flit_uart_tx_serializer #(
  parameter int         FLIT_WIDTH  = 32,
  parameter int         MAX_CREDITS = 8,
  parameter logic [7:0] COMMA_BYTE  = 8'hBC,
  localparam int        NUM_BYTES   = (FLIT_WIDTH + 7) / 8,
  localparam int        CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  input  logic                  credit_return,
  output logic [7:0]            uart_data,
  output logic                  uart_comma_sel,
  output logic                  uart_start,
  input  logic                  uart_busy,
  input  logic                  uart_done,
  output logic [CW-1:0]         credits,
  output logic                  credit_err,
  output logic                  tx_active
);

  localparam int             SW       = NUM_BYTES * 8;
  localparam int             IW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0]  CRED_MAX = CW'(MAX_CREDITS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, COMMA, WAIT_C, DATA, WAIT_D} state_t;

  state_t         state;
  logic [SW-1:0]  sreg;
  logic [IW-1:0]  byte_idx;
  logic           accept;

  assign flit_ready = !rst && (state == IDLE) && (credits != '0);
  assign accept     = flit_valid && flit_ready;
  assign tx_active  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      credits        <= CRED_MAX;
      credit_err     <= 1'b0;
      uart_start     <= 1'b0;
      uart_data      <= '0;
      uart_comma_sel <= 1'b0;
      byte_idx       <= '0;
      sreg           <= '0;
    end else begin
      uart_start <= 1'b0;

      // An accept and a return in the same cycle cancel; a return at full is a remote protocol error.
      case ({accept, credit_return})
        2'b10:   credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CRED_MAX) credit_err <= 1'b1;
          else                     credits    <= credits + CW'(1);
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= SW'(flit_in);
            state <= COMMA;
          end
        end
        COMMA: begin
          if (!uart_busy) begin
            uart_start     <= 1'b1;
            uart_data      <= COMMA_BYTE;
            uart_comma_sel <= 1'b1;
            state          <= WAIT_C;
          end
        end
        WAIT_C: begin
          if (uart_done) begin
            byte_idx <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          // Top byte of the shift register is always the next one on the wire.
          if (!uart_busy) begin
            uart_start     <= 1'b1;
            uart_data      <= sreg[SW-1 -: 8];
            uart_comma_sel <= 1'b0;
            sreg           <= sreg << 8;
            state          <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (uart_done) begin
            if (byte_idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + IW'(1);
              state    <= DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/flit_uart_tx_serializer.md
Name: flit_uart_tx_serializer

Overview:
- Downstream neighbour of a switch output port on an off-chip link.
- Accepts one flit at a time from the switch output (valid/ready), frames it with a leading comma character and serializes it byte-by-byte into the UART transmitter (start/done handshake).
- Gates transmission on a link-level credit counter replenished by the remote receiver, so the far-end input buffer never overflows.

Parameters:
- FLIT_WIDTH, 32, width of one flit in bits.
- NUM_BYTES, ceil(FLIT_WIDTH/8) = 4, data bytes per flit; the upper pad bits of the last byte are zero.
- MAX_CREDITS, 8, remote buffer depth; this is the credit reset value.
- COMMA_BYTE, 8'hBC, value driven on uart_data with uart_comma_sel=1 for the frame start.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flit_in  in  FLIT_WIDTH  flit from switch output port.
- flit_valid  in  1  flit_in valid (switch data_ready_out).
- flit_ready  out  1  flit accepted this cycle when high together with flit_valid (drives switch packet_sent).
- credit_return  in  1  one-cycle pulse; remote freed one buffer slot.
- uart_data  out  8  byte to the UART tx.
- uart_comma_sel  out  1  1 = comma/control character, 0 = data.
- uart_start  out  1  one-cycle pulse launching the byte.
- uart_busy  in  1  UART tx currently shifting.
- uart_done  in  1  one-cycle pulse; the current byte has finished.
- credits  out  $clog2(MAX_CREDITS+1)  current credit count.
- credit_err  out  1  sticky; a credit_return arrived while at MAX_CREDITS.
- tx_active  out  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, credits=MAX_CREDITS, credit_err=0.
  - uart_start=0, uart_data=0, uart_comma_sel=0, byte_idx=0, shift register=0.
  - flit_ready is forced 0 while rst is high.
  - Reset mid-frame abandons the frame with no further uart_start, and restores credits to MAX.
- flit_ready: combinational, = !rst && state==IDLE && credits!=0.
- States:
  - IDLE: on flit_valid && flit_ready, capture flit_in zero-extended to NUM_BYTES*8 bits, decrement credits, go to COMMA.
  - COMMA: wait until uart_busy==0. Then pulse uart_start for exactly one cycle with uart_data=COMMA_BYTE and uart_comma_sel=1, and go to WAIT_C.
  - WAIT_C: on uart_done, set byte_idx=0 and go to DATA.
  - DATA: wait until uart_busy==0. Then pulse uart_start with uart_comma_sel=0 and uart_data=byte[NUM_BYTES-1-byte_idx] (MSB byte first), and go to WAIT_D.
  - WAIT_D: on uart_done:
    - if byte_idx==NUM_BYTES-1, go to IDLE;
    - else increment byte_idx and go to DATA.
- Timing and hold rules:
  - uart_data and uart_comma_sel hold their value from the start pulse until the next start pulse.
  - Minimum latency: accept at cycle N gives comma uart_start at N+1 when uart_busy=0.
  - A new flit may be accepted the cycle after the last uart_done (IDLE reached).
  - uart_done outside the WAIT states is ignored.
- Credits:
  - accept only: decrement.
  - credit_return only: increment, saturating at MAX_CREDITS; a return at MAX sets credit_err.
  - Simultaneous accept and credit_return: count unchanged, no error.
  - credits==0 blocks acceptance; the switch holds flit_valid.
  - credit_return is honoured in every state.
- tx_active = state!=IDLE; reset value 0.

Test Plan:
- Single flit: credits=8, flit_in=32'hDEADBEEF valid. Required response:
  - flit_ready pulse, then 5 uart_start pulses (each acked with uart_done 10 cycles later);
  - bytes in order: BC(comma_sel=1), DE, AD, BE, EF(comma_sel=0);
  - credits goes to 7, tx_active falls the cycle after the 5th done.
- Back-to-back: two flits 32'h00000001 and 32'h00000002 with valid held. The second flit_ready must be the cycle after the first frame's last done, and credits reach 6.
- Credit exhaustion: 8 flits with no credit_return leave credits=0 and flit_ready low with valid held. One credit_return then gives flit_ready=1 the next cycle and the 9th flit is sent.
- Simultaneous accept and credit_return at credits=3: credits stays 3. A credit_return at credits=8 leaves credits at 8 and sets credit_err=1, which stays 1 until rst.
- uart_busy held high 20 cycles after accept: no uart_start until busy drops, then the comma is launched the same cycle busy is sampled low.
- rst pulse during WAIT_D of byte 2: no further uart_start, credits=8, state IDLE. The next flit is framed from the comma again.
